// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: stage tags,
// controller states and forwarding select encodings.
package hazard_pkg;

  // Tags carry a fixed-width destination; narrower register indices are zero-extended.
  localparam int TAG_AW = 8;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              reg_wrt;
    logic              is_load;
    logic              mem_en;
    logic              lr_wrt;
    logic              fl_wrt;
  } stage_tag_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } fsm_state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  localparam logic [1:0] FWD_LR  = 2'd3;

  localparam logic [1:0] FLF_REG  = 2'd0;
  localparam logic [1:0] FLF_EXME = 2'd1;
  localparam logic [1:0] FLF_MEWB = 2'd2;

  localparam stage_tag_t TAG_NONE = '0;

  // Register 0 is hardwired, so a write to it never produces a forward.
  function automatic logic reg_match(input stage_tag_t tag, input logic [TAG_AW-1:0] src);
    return tag.valid && tag.reg_wrt && (tag.rd == src) && (tag.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Combinational tag comparison: next forwarding selects for the decode
// instruction and the load-use hazard flag.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_rs1_is_LR,
  input  logic              id_uses_FL,
  input  stage_tag_t        ex_tag,
  input  stage_tag_t        mem_tag,
  output logic [1:0]        fwd1,
  output logic [1:0]        fwd2,
  output logic              fwd_lr,
  output logic [1:0]        fwd_fl,
  output logic              load_use
);

  logic rs1_ex, rs1_mem, rs2_ex, rs2_mem;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    fwd1     = FWD_REG;
    fwd2     = FWD_REG;
    fwd_lr   = 1'b0;
    fwd_fl   = FLF_REG;

    // An LR read occupies operand 1, so it never matches a general register.
    rs1_ex   = id_rs1_used && !id_rs1_is_LR && reg_match(ex_tag,  TAG_AW'(id_rs1));
    rs1_mem  = id_rs1_used && !id_rs1_is_LR && reg_match(mem_tag, TAG_AW'(id_rs1));
    rs2_ex   = id_rs2_used && reg_match(ex_tag,  TAG_AW'(id_rs2));
    rs2_mem  = id_rs2_used && reg_match(mem_tag, TAG_AW'(id_rs2));

    if (id_rs1_is_LR) begin
      if (ex_tag.valid && ex_tag.lr_wrt) begin
        fwd1   = FWD_LR;
        fwd_lr = 1'b0;
      end else if (mem_tag.valid && mem_tag.lr_wrt) begin
        fwd1   = FWD_LR;
        fwd_lr = 1'b1;
      end
    end else if (rs1_ex) begin
      fwd1 = FWD_ALU;
    end else if (rs1_mem) begin
      fwd1 = FWD_WB;
    end

    if (rs2_ex) begin
      fwd2 = FWD_ALU;
    end else if (rs2_mem) begin
      fwd2 = FWD_WB;
    end

    if (id_uses_FL) begin
      if (ex_tag.valid && ex_tag.fl_wrt) begin
        fwd_fl = FLF_EXME;
      end else if (mem_tag.valid && mem_tag.fl_wrt) begin
        fwd_fl = FLF_MEWB;
      end
    end

    load_use = ex_tag.valid && ex_tag.is_load && (rs1_ex || rs2_ex);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow tag pipeline, stall/bubble/flush/freeze
// control and registered forwarding selects. HAZARD_STATS_EN builds counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_rs1_is_LR,
  input  logic              id_uses_FL,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wrt_en,
  input  logic              id_mem_rd,
  input  logic              id_mem_en,
  input  logic              id_LR_wrt,
  input  logic              id_FL_wrt,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  output logic [1:0]        forward1_sel,
  output logic [1:0]        forward2_sel,
  output logic              forward_LR_sel,
  output logic [1:0]        forward_FL_sel,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              freeze,
  output logic [STAT_W-1:0] stat_lu,
  output logic [STAT_W-1:0] stat_mw,
  output logic [STAT_W-1:0] stat_fl
);

  fsm_state_t state, state_nxt;
  stage_tag_t ex_tag, mem_tag, wb_tag, id_tag;

  logic [1:0] fwd1_nxt, fwd2_nxt, fwd_fl_nxt;
  logic       fwd_lr_nxt, load_use;
  logic       mem_busy, lu_stall, do_flush;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_select (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rs1_is_LR (id_rs1_is_LR),
    .id_uses_FL   (id_uses_FL),
    .ex_tag       (ex_tag),
    .mem_tag      (mem_tag),
    .fwd1         (fwd1_nxt),
    .fwd2         (fwd2_nxt),
    .fwd_lr       (fwd_lr_nxt),
    .fwd_fl       (fwd_fl_nxt),
    .load_use     (load_use)
  );

  always_comb begin
    id_tag         = TAG_NONE;
    id_tag.valid   = 1'b1;
    id_tag.rd      = TAG_AW'(id_rd);
    id_tag.reg_wrt = id_reg_wrt_en;
    id_tag.is_load = id_mem_rd;
    id_tag.mem_en  = id_mem_en;
    id_tag.lr_wrt  = id_LR_wrt;
    id_tag.fl_wrt  = id_FL_wrt;
  end

  // Freeze is taken combinationally on the first busy cycle so the access in
  // MEM never slips forward; the FSM only records that a wait is in progress.
  always_comb begin
    mem_busy    = mem_tag.valid && mem_tag.mem_en && !mem_ready;
    do_flush    = ex_redirect && !mem_busy;
    lu_stall    = load_use && !mem_busy && !ex_redirect;

    freeze      = mem_busy;
    stall_if    = mem_busy || lu_stall;
    stall_id    = mem_busy || lu_stall;
    bubble_ex   = lu_stall;
    flush_if_id = do_flush;
    flush_id_ex = do_flush;

    state_nxt   = RUN;
    if (mem_busy) begin
      state_nxt = MEM_WAIT;
    end else if (lu_stall) begin
      state_nxt = LU_STALL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state          <= RUN;
      ex_tag         <= TAG_NONE;
      mem_tag        <= TAG_NONE;
      wb_tag         <= TAG_NONE;
      forward1_sel   <= FWD_REG;
      forward2_sel   <= FWD_REG;
      forward_LR_sel <= 1'b0;
      forward_FL_sel <= FLF_REG;
    end else begin
      state <= state_nxt;
      if (!mem_busy) begin
        wb_tag  <= mem_tag;
        mem_tag <= ex_tag;
        if (lu_stall || do_flush || !id_valid) begin
          ex_tag         <= TAG_NONE;
          forward1_sel   <= FWD_REG;
          forward2_sel   <= FWD_REG;
          forward_LR_sel <= 1'b0;
          forward_FL_sel <= FLF_REG;
        end else begin
          ex_tag         <= id_tag;
          forward1_sel   <= fwd1_nxt;
          forward2_sel   <= fwd2_nxt;
          forward_LR_sel <= fwd_lr_nxt;
          forward_FL_sel <= fwd_fl_nxt;
        end
      end
    end
  end

  // Invalid tags are always loaded as all-zero, so a stale payload never rides along.
  a_wb_tag_clean: assert property (@(posedge clk) disable iff (!rst_n)
    !wb_tag.valid |-> (wb_tag == TAG_NONE));

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] lu_cnt, mw_cnt, fl_cnt;

  // A wait cycle is any frozen cycle, including the first one before MEM_WAIT is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_cnt <= '0;
      mw_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (state == LU_STALL && lu_cnt != '1) lu_cnt <= lu_cnt + STAT_W'(1);
      if (mem_busy && mw_cnt != '1)          mw_cnt <= mw_cnt + STAT_W'(1);
      if (do_flush && fl_cnt != '1)          fl_cnt <= fl_cnt + STAT_W'(1);
    end
  end

  assign stat_lu = lu_cnt;
  assign stat_mw = mw_cnt;
  assign stat_fl = fl_cnt;
`else
  assign stat_lu = '0;
  assign stat_mw = '0;
  assign stat_fl = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expectations queued by the stimulus
// and checked by an independent monitor on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rs1_is_LR, id_uses_FL;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_wrt_en, id_mem_rd, id_mem_en, id_LR_wrt, id_FL_wrt;
  logic       ex_redirect, mem_ready;
  logic [1:0] forward1_sel, forward2_sel, forward_FL_sel;
  logic       forward_LR_sel;
  logic       stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze;
  logic [31:0] stat_lu, stat_mw, stat_fl;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .STAT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rs1_is_LR   (id_rs1_is_LR),
    .id_uses_FL     (id_uses_FL),
    .id_rd          (id_rd),
    .id_reg_wrt_en  (id_reg_wrt_en),
    .id_mem_rd      (id_mem_rd),
    .id_mem_en      (id_mem_en),
    .id_LR_wrt      (id_LR_wrt),
    .id_FL_wrt      (id_FL_wrt),
    .ex_redirect    (ex_redirect),
    .mem_ready      (mem_ready),
    .forward1_sel   (forward1_sel),
    .forward2_sel   (forward2_sel),
    .forward_LR_sel (forward_LR_sel),
    .forward_FL_sel (forward_FL_sel),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .bubble_ex      (bubble_ex),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .freeze         (freeze),
    .stat_lu        (stat_lu),
    .stat_mw        (stat_mw),
    .stat_fl        (stat_fl)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2, is_lr, use_fl;
    logic [4:0] rd;
    logic       wr, ld, men, lrw, flw;
  } dec_t;

  // Expected outputs: selects, then {stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze}.
  typedef struct packed {
    logic [1:0] f1, f2;
    logic       flr;
    logic [1:0] ffl;
    logic [5:0] ctl;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } item_t;

  localparam logic [5:0] C_NO = 6'b000000;
  localparam logic [5:0] C_LU = 6'b111000;
  localparam logic [5:0] C_FL = 6'b000110;
  localparam logic [5:0] C_FZ = 6'b110001;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic dec_t nop();
    return '0;
  endfunction

  function automatic dec_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    dec_t d = '0;
    d.v = 1'b1; d.rs1 = a; d.rs2 = b; d.u1 = 1'b1; d.u2 = 1'b1; d.rd = rd; d.wr = 1'b1;
    return d;
  endfunction

  function automatic dec_t load(input logic [4:0] rd, input logic [4:0] a);
    dec_t d = '0;
    d.v = 1'b1; d.rs1 = a; d.u1 = 1'b1; d.rd = rd; d.wr = 1'b1; d.ld = 1'b1; d.men = 1'b1;
    return d;
  endfunction

  function automatic dec_t store(input logic [4:0] a, input logic [4:0] b);
    dec_t d = '0;
    d.v = 1'b1; d.rs1 = a; d.rs2 = b; d.u1 = 1'b1; d.u2 = 1'b1; d.men = 1'b1;
    return d;
  endfunction

  function automatic dec_t cmp(input logic [4:0] a, input logic [4:0] b);
    dec_t d = '0;
    d.v = 1'b1; d.rs1 = a; d.rs2 = b; d.u1 = 1'b1; d.u2 = 1'b1; d.flw = 1'b1;
    return d;
  endfunction

  function automatic dec_t br();
    dec_t d = '0;
    d.v = 1'b1; d.use_fl = 1'b1;
    return d;
  endfunction

  function automatic dec_t bl();
    dec_t d = '0;
    d.v = 1'b1; d.lrw = 1'b1;
    return d;
  endfunction

  function automatic dec_t ret();
    dec_t d = '0;
    d.v = 1'b1; d.u1 = 1'b1; d.is_lr = 1'b1;
    return d;
  endfunction

  function automatic exp_t xp(input logic [1:0] f1, input logic [1:0] f2, input logic flr,
                              input logic [1:0] ffl, input logic [5:0] ctl);
    exp_t e;
    e.f1 = f1; e.f2 = f2; e.flr = flr; e.ffl = ffl; e.ctl = ctl;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input dec_t d);
    id_valid      = d.v;
    id_rs1        = d.rs1;
    id_rs2        = d.rs2;
    id_rs1_used   = d.u1;
    id_rs2_used   = d.u2;
    id_rs1_is_LR  = d.is_lr;
    id_uses_FL    = d.use_fl;
    id_rd         = d.rd;
    id_reg_wrt_en = d.wr;
    id_mem_rd     = d.ld;
    id_mem_en     = d.men;
    id_LR_wrt     = d.lrw;
    id_FL_wrt     = d.flw;
  endtask

  // One pipeline cycle: inputs held for the whole cycle, expectation for this cycle queued.
  task automatic step(input dec_t d, input logic redir, input logic rdy, input logic rst,
                      input exp_t e, input string name);
    item_t it;
    @(posedge clk);
    #1;
    drive(d);
    ex_redirect = redir;
    mem_ready   = rdy;
    rst_n       = rst;
    it.e        = e;
    it.name     = name;
    q.push_back(it);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      item_t it;
      exp_t  act;
      it = q.pop_front();
      act.f1  = forward1_sel;
      act.f2  = forward2_sel;
      act.flr = forward_LR_sel;
      act.ffl = forward_FL_sel;
      act.ctl = {stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze};
      check(it.name, 32'(act), 32'(it.e));
    end
  end

  task automatic check_stats(input string tag, input int lu, input int mw, input int fl);
    check({tag, "_stat_lu"}, stat_lu, lu);
    check({tag, "_stat_mw"}, stat_mw, mw);
    check({tag, "_stat_fl"}, stat_fl, fl);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(nop());
    ex_redirect = 1'b0;
    mem_ready   = 1'b1;

    step(nop(),          0, 1, 0, xp(0, 0, 0, 0, C_NO), "reset_state");
    // Distance 1 and distance 2 register forwarding, register 0 never forwarded
    step(alu(3, 1, 2),   0, 1, 1, xp(0, 0, 0, 0, C_NO), "d1_prod");
    step(alu(4, 3, 5),   0, 1, 1, xp(0, 0, 0, 0, C_NO), "d1_cons_decode");
    step(nop(),          0, 1, 1, xp(1, 0, 0, 0, C_NO), "d1_fwd_alu");
    step(alu(3, 1, 2),   0, 1, 1, xp(0, 0, 0, 0, C_NO), "d2_prod");
    step(nop(),          0, 1, 1, xp(0, 0, 0, 0, C_NO), "d2_gap");
    step(alu(6, 7, 3),   0, 1, 1, xp(0, 0, 0, 0, C_NO), "d2_cons_decode");
    step(alu(0, 1, 2),   0, 1, 1, xp(0, 2, 0, 0, C_NO), "d2_fwd_wb");
    step(alu(8, 0, 0),   0, 1, 1, xp(0, 0, 0, 0, C_NO), "r0_cons_decode");
    step(nop(),          0, 1, 1, xp(0, 0, 0, 0, C_NO), "r0_no_fwd");
    // Load-use: one bubble, then WB forwarding
    step(load(3, 1),     0, 1, 1, xp(0, 0, 0, 0, C_NO), "lu_load");
    step(alu(4, 3, 1),   0, 1, 1, xp(0, 0, 0, 0, C_LU), "lu_stall");
    step(alu(4, 3, 1),   0, 1, 1, xp(0, 0, 0, 0, C_NO), "lu_one_cycle");
    step(nop(),          0, 1, 1, xp(2, 0, 0, 0, C_NO), "lu_fwd_wb");
    // Store stalls in MEM for three cycles; tags and selects hold
    step(alu(12, 1, 2),  0, 1, 1, xp(0, 0, 0, 0, C_NO), "st_prod");
    step(store(12, 2),   0, 1, 1, xp(0, 0, 0, 0, C_NO), "st_decode");
    step(alu(13, 12, 5), 0, 1, 1, xp(1, 0, 0, 0, C_NO), "st_fwd_alu");
    step(alu(14, 13, 1), 0, 0, 1, xp(2, 0, 0, 0, C_FZ), "freeze_1");
    step(alu(14, 13, 1), 0, 0, 1, xp(2, 0, 0, 0, C_FZ), "freeze_2");
    step(alu(14, 13, 1), 0, 0, 1, xp(2, 0, 0, 0, C_FZ), "freeze_3");
    step(alu(14, 13, 1), 0, 1, 1, xp(2, 0, 0, 0, C_NO), "freeze_release");
    step(nop(),          0, 1, 1, xp(1, 0, 0, 0, C_NO), "post_freeze_fwd");
    // Flags and link register forwarding
    step(cmp(1, 2),      0, 1, 1, xp(0, 0, 0, 0, C_NO), "fl_cmp");
    step(br(),           0, 1, 1, xp(0, 0, 0, 0, C_NO), "fl_br_decode");
    step(cmp(1, 2),      0, 1, 1, xp(0, 0, 0, 1, C_NO), "fl_exme");
    step(nop(),          0, 1, 1, xp(0, 0, 0, 0, C_NO), "fl_gap");
    step(br(),           0, 1, 1, xp(0, 0, 0, 0, C_NO), "fl_br2_decode");
    step(bl(),           0, 1, 1, xp(0, 0, 0, 2, C_NO), "fl_mewb");
    step(ret(),          0, 1, 1, xp(0, 0, 0, 0, C_NO), "lr_ret_decode");
    step(ret(),          0, 1, 1, xp(3, 0, 0, 0, C_NO), "lr_exme");
    step(nop(),          0, 1, 1, xp(3, 0, 1, 0, C_NO), "lr_mewb");
    // Redirect wins over load-use
    step(load(5, 1),     0, 1, 1, xp(0, 0, 0, 0, C_NO), "redir_load");
    step(alu(6, 5, 5),   1, 1, 1, xp(0, 0, 0, 0, C_FL), "redir_over_lu");
    step(nop(),          0, 1, 1, xp(0, 0, 0, 0, C_NO), "post_redir");
    // Redirect held during a memory wait flushes on the first unfrozen cycle
    step(load(7, 1),     0, 1, 1, xp(0, 0, 0, 0, C_NO), "mw_load");
    step(nop(),          0, 1, 1, xp(0, 0, 0, 0, C_NO), "mw_gap");
    step(alu(9, 7, 1),   1, 0, 1, xp(0, 0, 0, 0, C_FZ), "redir_frozen_1");
    step(alu(9, 7, 1),   1, 0, 1, xp(0, 0, 0, 0, C_FZ), "redir_frozen_2");
    step(alu(9, 7, 1),   1, 1, 1, xp(0, 0, 0, 0, C_FL), "redir_unfrozen");
    step(nop(),          0, 1, 1, xp(0, 0, 0, 0, C_NO), "flush_clears_sel");
    @(negedge clk);
`ifdef HAZARD_STATS_EN
    check_stats("run", 1, 5, 2);
`else
    check_stats("run", 0, 0, 0);
`endif
    // Reset while the controller sits in LU_STALL with a load in MEM
    step(load(3, 1),     0, 1, 1, xp(0, 0, 0, 0, C_NO), "rst_load");
    step(alu(4, 3, 1),   0, 1, 1, xp(0, 0, 0, 0, C_LU), "rst_lu_stall");
    step(alu(4, 3, 1),   0, 1, 0, xp(0, 0, 0, 0, C_NO), "rst_mid_stall");
    step(alu(4, 3, 1),   0, 1, 1, xp(0, 0, 0, 0, C_NO), "rst_release");
    step(nop(),          0, 1, 1, xp(0, 0, 0, 0, C_NO), "rst_cleared_tags");
    @(negedge clk);
    check_stats("after_rst", 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
